// File: rtl/axi_sram_wr_slave_if.sv
// AXI write-side bundle (AW, W, B channels) between interconnect and SRAM slave.
// Ports: aw*_i/awready_o, w*_i/wready_o, b*_o/bready_i; suffixes are from the slave's view.
interface axi_sram_wr_slave_if #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    logic [ID_BITS-1:0]     awid_i;
    logic [ADDR_BITS-1:0]   awaddr_i;
    logic [3:0]             awlen_i;
    logic [2:0]             awsize_i;
    logic [1:0]             awburst_i;
    logic                   awvalid_i;
    logic                   awready_o;

    logic [DATA_BITS-1:0]   wdata_i;
    logic [DATA_BITS/8-1:0] wstrb_i;
    logic                   wlast_i;
    logic                   wvalid_i;
    logic                   wready_o;

    logic [ID_BITS-1:0]     bid_o;
    logic [1:0]             bresp_o;
    logic                   bvalid_o;
    logic                   bready_i;

    modport master (
        output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        input  awready_o,
        output wdata_i, wstrb_i, wlast_i, wvalid_i,
        input  wready_o,
        input  bid_o, bresp_o, bvalid_o,
        output bready_i
    );

    modport slave (
        input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        output awready_o,
        input  wdata_i, wstrb_i, wlast_i, wvalid_i,
        output wready_o,
        output bid_o, bresp_o, bvalid_o,
        input  bready_i
    );
endinterface

// File: rtl/axi_sram_wr_slave.sv
// AXI write slave: one AW at a time, each W beat becomes a single-cycle SRAM write.
// Ports: clk, rst (async active-low), bus (AXI AW/W/B slave), sram_cs/we/a/di outputs.
module axi_sram_wr_slave #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int MEM_AW    = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_sram_wr_slave_if.slave      bus,
    output logic                    sram_cs_o,
    output logic [DATA_BITS/8-1:0]  sram_we_o,
    output logic [MEM_AW-1:0]       sram_a_o,
    output logic [DATA_BITS-1:0]    sram_di_o
);
    localparam int SB = DATA_BITS / 8;
    localparam logic [MEM_AW-1:0] A_ONE = MEM_AW'(1);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP} state_t;

    state_t              state_q, state_d;
    logic [ID_BITS-1:0]  id_q, id_d;
    logic [3:0]          len_q, len_d;
    logic [1:0]          burst_q, burst_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    // Set once beat len+1 is taken; later beats are consumed but not written.
    logic                ovf_q, ovf_d;

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.awaddr_i[ADDR_BITS-1:MEM_AW+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        burst_d   = burst_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        sram_cs_o = 1'b0;
        sram_we_o = '0;
        sram_a_o  = addr_q;
        sram_di_o = bus.wdata_i;

        unique case (state_q)
            IDLE: begin
                if (bus.awvalid_i) begin
                    id_d    = bus.awid_i;
                    len_d   = bus.awlen_i;
                    burst_d = bus.awburst_i;
                    addr_d  = bus.awaddr_i[MEM_AW+1:2];
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    // Only 32-bit beats, aligned, INCR/FIXED are supported.
                    err_d   = (bus.awsize_i != 3'b010) || bus.awburst_i[1]
                              || (bus.awaddr_i[1:0] != 2'b00);
                    state_d = WDATA;
                end
            end
            WDATA: begin
                if (bus.wvalid_i) begin
                    if (!ovf_q) begin
                        sram_cs_o = 1'b1;
                        sram_we_o = bus.wstrb_i;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == len_q) ovf_d = 1'b1;
                    if (burst_q == 2'b01) addr_d = addr_q + A_ONE;
                    if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
                    if (bus.wlast_i) begin
                        if (cnt_q != len_q) err_d = 1'b1;
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                if (bus.bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.awready_o = (state_q == IDLE);
    assign bus.wready_o  = (state_q == WDATA);
    assign bus.bvalid_o  = (state_q == WRESP);
    assign bus.bid_o     = id_q;
    assign bus.bresp_o   = err_q ? 2'b10 : 2'b00;

    logic [SB-1:0] unused_sb;
    assign unused_sb = '0;
endmodule

// File: tb/tb_axi_sram_wr_slave.sv
// Directed scoreboard bench for axi_sram_wr_slave.
// Expected SRAM writes and B responses are queued at drive time and popped by a monitor.
module tb_axi_sram_wr_slave;
    localparam int IDB = 8;
    localparam int AB  = 32;
    localparam int DB  = 32;
    localparam int MAW = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_sram_wr_slave_if #(.ID_BITS(IDB), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();

    logic            sram_cs;
    logic [3:0]      sram_we;
    logic [MAW-1:0]  sram_a;
    logic [DB-1:0]   sram_di;

    axi_sram_wr_slave #(
        .ID_BITS(IDB), .ADDR_BITS(AB), .DATA_BITS(DB), .MEM_AW(MAW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sram_cs_o(sram_cs),
        .sram_we_o(sram_we),
        .sram_a_o(sram_a),
        .sram_di_o(sram_di)
    );

    typedef struct packed {
        logic [MAW-1:0] a;
        logic [3:0]     we;
        logic [DB-1:0]  d;
    } wexp_t;
    typedef struct packed {
        logic [IDB-1:0] id;
        logic [1:0]     resp;
    } bexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    int errors = 0;
    int checks = 0;
    int n_pushed = 0;
    int n_writes = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [MAW-1:0] a, input logic [3:0] we,
                          input logic [DB-1:0] d);
        wexp_t e;
        e.a = a; e.we = we; e.d = d;
        wq.push_back(e);
        n_pushed++;
    endtask

    task automatic push_b(input logic [IDB-1:0] id, input logic [1:0] resp);
        bexp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst && sram_cs) begin
            wexp_t e;
            n_writes++;
            chk("write_expected", 64'(wq.size() > 0), 64'd1);
            if (wq.size() > 0) begin
                e = wq.pop_front();
                chk("sram_a", 64'(sram_a), 64'(e.a));
                chk("sram_we", 64'(sram_we), 64'(e.we));
                chk("sram_di", 64'(sram_di), 64'(e.d));
            end
        end
        if (rst && bus.bvalid_o && bus.bready_i) begin
            bexp_t b;
            chk("b_expected", 64'(bq.size() > 0), 64'd1);
            if (bq.size() > 0) begin
                b = bq.pop_front();
                chk("bid", 64'(bus.bid_o), 64'(b.id));
                chk("bresp", 64'(bus.bresp_o), 64'(b.resp));
            end
        end
    end

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
        int n = 0;
        bus.awid_i    = id;
        bus.awaddr_i  = addr;
        bus.awlen_i   = len;
        bus.awsize_i  = size;
        bus.awburst_i = burst;
        bus.awvalid_i = 1'b1;
        while (bus.awready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("aw_wait", 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        bus.awvalid_i = 1'b0;
        chk("wready_after_aw", 64'(bus.wready_o), 64'd1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] strb,
                        input logic last);
        int n = 0;
        bus.wdata_i  = d;
        bus.wstrb_i  = strb;
        bus.wlast_i  = last;
        bus.wvalid_i = 1'b1;
        while (bus.wready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w_wait", 64'(n < 20), 64'd1);
        @(posedge clk); #1;
        bus.wvalid_i = 1'b0;
        bus.wlast_i  = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_awready"}, 64'(bus.awready_o), 64'd1);
        chk({tag, "_wready"}, 64'(bus.wready_o), 64'd0);
        chk({tag, "_bvalid"}, 64'(bus.bvalid_o), 64'd0);
        chk({tag, "_bid"}, 64'(bus.bid_o), 64'd0);
        chk({tag, "_bresp"}, 64'(bus.bresp_o), 64'd0);
        chk({tag, "_cs"}, 64'(sram_cs), 64'd0);
        chk({tag, "_we"}, 64'(sram_we), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        bus.awid_i = '0; bus.awaddr_i = '0; bus.awlen_i = '0;
        bus.awsize_i = '0; bus.awburst_i = '0; bus.awvalid_i = 1'b0;
        bus.wdata_i = '0; bus.wstrb_i = '0; bus.wlast_i = 1'b0;
        bus.wvalid_i = 1'b0; bus.bready_i = 1'b1;

        #2;
        reset_vals("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // single beat
        do_aw(8'h12, 32'h100, 4'd0, 3'd2, 2'b01);
        chk("awready_busy", 64'(bus.awready_o), 64'd0);
        push_w(14'h40, 4'hF, 32'hDEADBEEF);
        push_b(8'h12, 2'b00);
        do_w(32'hDEADBEEF, 4'hF, 1'b1);
        chk("bvalid_m1", 64'(bus.bvalid_o), 64'd1);
        @(posedge clk); #1;
        chk("awready_after_b", 64'(bus.awready_o), 64'd1);

        // INCR len=3 with bready held low
        bus.bready_i = 1'b0;
        do_aw(8'h34, 32'h200, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            d = 32'h11111111 * (i + 1);
            push_w(14'(14'h80 + i), 4'(1 << i), d);
            if (i == 3) push_b(8'h34, 2'b00);
            do_w(d, 4'(1 << i), i == 3);
        end
        for (int k = 0; k < 3; k++) begin
            chk("bvalid_hold", 64'(bus.bvalid_o), 64'd1);
            chk("bid_hold", 64'(bus.bid_o), 64'h34);
            chk("bresp_hold", 64'(bus.bresp_o), 64'd0);
            @(posedge clk); #1;
        end
        chk("bvalid_hold4", 64'(bus.bvalid_o), 64'd1);
        bus.bready_i = 1'b1;
        @(posedge clk); #1;
        chk("awready_post_b", 64'(bus.awready_o), 64'd1);
        chk("bvalid_post_b", 64'(bus.bvalid_o), 64'd0);

        // FIXED len=2
        do_aw(8'h56, 32'h40, 4'd2, 3'd2, 2'b00);
        for (int i = 0; i < 3; i++) begin
            d = 32'hA0A0_0000 + i;
            push_w(14'h10, 4'hF, d);
            if (i == 2) push_b(8'h56, 2'b00);
            do_w(d, 4'hF, i == 2);
        end

        // early wlast: len=3, last on beat 2
        do_aw(8'h78, 32'h300, 4'd3, 3'd2, 2'b01);
        push_w(14'hC0, 4'hF, 32'h0000_0001);
        do_w(32'h0000_0001, 4'hF, 1'b0);
        push_w(14'hC1, 4'hF, 32'h0000_0002);
        push_b(8'h78, 2'b10);
        do_w(32'h0000_0002, 4'hF, 1'b1);

        // overrun: 5 beats for len=3, fifth dropped
        do_aw(8'h9A, 32'h400, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 5; i++) begin
            d = 32'hB000_0000 + i;
            if (i < 4) push_w(14'(14'h100 + i), 4'hF, d);
            if (i == 4) push_b(8'h9A, 2'b10);
            do_w(d, 4'hF, i == 4);
        end

        // word address wrap
        do_aw(8'h5A, 32'hFFFC, 4'd1, 3'd2, 2'b01);
        push_w(14'h3FFF, 4'hF, 32'hCAFE_0001);
        do_w(32'hCAFE_0001, 4'hF, 1'b0);
        push_w(14'h0000, 4'h3, 32'hCAFE_0002);
        push_b(8'h5A, 2'b00);
        do_w(32'hCAFE_0002, 4'h3, 1'b1);

        // bad size and bad burst type: still written, SLVERR
        do_aw(8'h21, 32'h500, 4'd0, 3'd1, 2'b01);
        push_w(14'h140, 4'hF, 32'h5151_5151);
        push_b(8'h21, 2'b10);
        do_w(32'h5151_5151, 4'hF, 1'b1);
        do_aw(8'h22, 32'h504, 4'd0, 3'd2, 2'b10);
        push_w(14'h141, 4'hF, 32'h5252_5252);
        push_b(8'h22, 2'b10);
        do_w(32'h5252_5252, 4'hF, 1'b1);

        // reset mid-burst
        do_aw(8'h66, 32'h800, 4'd3, 3'd2, 2'b01);
        push_w(14'h200, 4'hF, 32'h6666_0000);
        do_w(32'h6666_0000, 4'hF, 1'b0);
        #2;
        rst = 1'b0;
        bus.wvalid_i = 1'b1;
        bus.wdata_i  = 32'h6666_0001;
        #1;
        reset_vals("midrst");
        @(negedge clk);
        bus.wvalid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("awready_rel", 64'(bus.awready_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_bvalid", 64'(bus.bvalid_o), 64'd0);
        end

        // AW and W together, then gapped beats
        bus.awid_i = 8'h77; bus.awaddr_i = 32'h900; bus.awlen_i = 4'd2;
        bus.awsize_i = 3'd2; bus.awburst_i = 2'b01; bus.awvalid_i = 1'b1;
        bus.wdata_i = 32'h7777_0000; bus.wstrb_i = 4'h3;
        bus.wlast_i = 1'b0; bus.wvalid_i = 1'b1;
        push_w(14'h240, 4'h3, 32'h7777_0000);
        chk("aw_w_wready", 64'(bus.wready_o), 64'd0);
        chk("aw_w_cs", 64'(sram_cs), 64'd0);
        @(posedge clk); #1;
        bus.awvalid_i = 1'b0;
        chk("aw_w_wready1", 64'(bus.wready_o), 64'd1);
        @(posedge clk); #1;
        bus.wvalid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("gap_cs", 64'(sram_cs), 64'd0);
        end
        push_w(14'h241, 4'hC, 32'h7777_0001);
        do_w(32'h7777_0001, 4'hC, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        push_w(14'h242, 4'hF, 32'h7777_0002);
        push_b(8'h77, 2'b00);
        do_w(32'h7777_0002, 4'hF, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("bq_empty", 64'(bq.size()), 64'd0);
        chk("write_count", 64'(n_writes), 64'(n_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
